binarize_frame_ctrl: RTL and testbench
======================================

Name: binarize_frame_ctrl

Overview:
- Frame-level sequencer for the pixel binarization comparator.
- Walks an image memory of 2^ADDR_W pixels. In adaptive mode it first accumulates the frame and derives a mean threshold; in fixed mode it uses a supplied threshold.
- Then streams every pixel through the compare (pixel >= threshold -> 255, else 0) and writes the 8-bit result to an output memory.
- Sits between the reconstruction image buffer and the binary-image buffer of the CT pipeline.

Parameters:
- ADDR_W, 14, log2 of pixel count per frame (N = 2^ADDR_W; 14 gives 128x128).
- DATA_W, 17, width of input pixel words.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request to process one frame; sampled only in IDLE
- mode  input  1  1 = adaptive (mean) threshold, 0 = fixed threshold; sampled with start
- fix_thr  input  8  fixed threshold; latched with start when mode=0
- mem_rd  output  1  read strobe to image memory
- mem_addr  output  ADDR_W  read address
- mem_data  input  DATA_W  read data, valid the cycle after mem_rd (registered memory)
- wr_en  output  1  write strobe to binary-image memory
- wr_addr  output  ADDR_W  write address
- wr_data  output  8  binarized pixel, 8'd255 or 8'd0
- thr_out  output  8  threshold in use; holds after frame
- busy  output  1  high in ACC, CALC, BIN
- done  output  1  one-cycle pulse in DONE

Behaviour:
- Reset (async, any state, including mid-frame) forces:
  - state IDLE
  - all outputs 0
  - accumulator, address counter, read-valid flag 0
  - no further writes; the partial frame is abandoned.
- States: IDLE, ACC, CALC, BIN, DONE.
  - IDLE: start=1 at edge k -> ACC if mode=1, else BIN, entered at k+1; thr_out <= fix_thr at that edge when mode=0. start while not IDLE is ignored.
  - ACC, N+1 cycles:
    - Cycles 1..N: mem_rd=1, mem_addr=0..N-1 incrementing.
    - Cycles 2..N+1: sum += mem_data (zero-extended).
    - Exits after the last capture.
    - sum width DATA_W+ADDR_W; cleared on ACC entry; no overflow possible.
  - CALC, 1 cycle: thr_out <= (sum>>ADDR_W) > 255 ? 255 : (sum>>ADDR_W)[7:0].
  - BIN, N+1 cycles:
    - Cycles 1..N: mem_rd=1, mem_addr=0..N-1.
    - Cycles 2..N+1: wr_en=1, wr_addr = previous mem_addr, wr_data = (mem_data >= {zero-extended thr_out}) ? 255 : 0.
    - Compare is unsigned and full width.
  - DONE, 1 cycle: done=1, busy=0, then IDLE.
- mem_rd/mem_addr are registered state outputs. wr_en/wr_addr come from a registered one-cycle read-valid delay. wr_data is combinational from mem_data and thr_out.
- Address counter wraps N-1 -> 0 at each state change; it never issues address N.
- Latency from the start edge k:
  - adaptive: done high in cycle k+2N+4
  - fixed: done high in cycle k+N+2
- thr_out holds its value from frame end until the next frame's CALC or fixed-mode start.
- start in the same cycle as DONE is ignored; it is accepted only in IDLE.

Test Plan:
- ADDR_W=2, mem={10,20,30,40}, start mode=1 -> thr_out=25; writes addr0..3 = {0,0,255,255}; done exactly 12 cycles after start edge.
- Same mem, mode=0, fix_thr=20 -> writes {0,255,255,255} (equality gives 255); thr_out=20; done 6 cycles after start; no ACC/CALC cycles.
- mem={1000,1000,1000,1000}, mode=1 -> mean 1000 clamps, thr_out=255; all writes 255. mem={0x1FFFF x4} -> no accumulator overflow, thr_out=255.
- start pulsed again during BIN with mode=0, fix_thr=99 -> ignored; thr_out unchanged; exactly 4 writes; one done pulse.
- reset asserted mid-BIN after 2 writes -> outputs 0 immediately (async), no further wr_en. After release, a new start runs a full correct frame.
- Back-to-back frames: start one cycle after done with different mode -> correct independent results; thr_out updates only at the new frame's CALC or start.

Source files
------------

// File: rtl/binarize_frame_ctrl.sv
// Frame sequencer for the pixel binarizer. It walks the image memory, optionally
// derives a mean threshold, then writes 255/0 per pixel to the binary-image memory.
module binarize_frame_ctrl #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 17
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mode,
   input  logic [7:0]        fix_thr,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [7:0]        wr_data,
   output logic [7:0]        thr_out,
   output logic              busy,
   output logic              done
);

   localparam int SUM_W = DATA_W + ADDR_W;

   typedef enum logic [2:0] {IDLE, ACC, CALC, BIN, DONE} state_t;

   state_t            state, nxt;
   logic              rvalid;
   logic [SUM_W-1:0]  sum;
   logic [SUM_W-1:0]  mean;
   logic              scan_end;

   assign mean     = sum >> ADDR_W;
   // Last data beat of a scan: the read strobe has dropped but its data is arriving.
   assign scan_end = rvalid && !mem_rd;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (start) nxt = mode ? ACC : BIN;
         ACC:     if (scan_end) nxt = CALC;
         CALC:    nxt = BIN;
         BIN:     if (scan_end) nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      busy    = 1'b0;
      done    = 1'b0;
      wr_en   = 1'b0;
      wr_data = '0;
      case (state)
         ACC, CALC: busy = 1'b1;
         BIN: begin
            busy  = 1'b1;
            wr_en = rvalid;
            if (rvalid && (mem_data >= {{(DATA_W-8){1'b0}}, thr_out}))
               wr_data = 8'd255;
         end
         DONE:    done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_rd   <= 1'b0;
         mem_addr <= '0;
         rvalid   <= 1'b0;
         wr_addr  <= '0;
         sum      <= '0;
         thr_out  <= '0;
      end else begin
         rvalid  <= mem_rd;
         wr_addr <= mem_addr;
         if (state == ACC && rvalid)
            sum <= sum + SUM_W'(mem_data);
         case (state)
            IDLE: begin
               if (start) begin
                  mem_rd   <= 1'b1;
                  mem_addr <= '0;
                  if (mode) sum     <= '0;
                  else      thr_out <= fix_thr;
               end
            end
            ACC, BIN: begin
               // Wrap to 0 on the final read so address N is never issued.
               if (mem_rd) begin
                  if (&mem_addr) begin
                     mem_rd   <= 1'b0;
                     mem_addr <= '0;
                  end else begin
                     mem_addr <= mem_addr + ADDR_W'(1);
                  end
               end
            end
            CALC: begin
               thr_out  <= (mean > SUM_W'(255)) ? 8'd255 : mean[7:0];
               mem_rd   <= 1'b1;
               mem_addr <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_binarize_frame_ctrl.sv
// Directed bench for binarize_frame_ctrl with a 4-pixel frame and a registered memory model.
module tb_binarize_frame_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        mode = 1'b0;
   logic [7:0]  fix_thr = '0;
   logic        mem_rd;
   logic [1:0]  mem_addr;
   logic [16:0] mem_data = '0;
   logic        wr_en;
   logic [1:0]  wr_addr;
   logic [7:0]  wr_data;
   logic [7:0]  thr_out;
   logic        busy;
   logic        done;

   logic [16:0] mem [4];
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [7:0]  prev_thr = '0;

   binarize_frame_ctrl #(.ADDR_W(2), .DATA_W(17)) dut (
      .clk(clk), .reset(reset), .start(start), .mode(mode), .fix_thr(fix_thr),
      .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .thr_out(thr_out), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];

   typedef struct {
      logic            mode;
      logic [7:0]      fthr;
      logic [3:0][16:0] m;
      logic [7:0]      ethr;
      logic [3:0][7:0] ew;
      int              elat;
   } vec_t;

   vec_t vecs [8];

   function automatic vec_t mk(input logic md, input logic [7:0] ft,
                               input logic [16:0] m0, m1, m2, m3,
                               input logic [7:0] et,
                               input logic [7:0] w0, w1, w2, w3,
                               input int lat);
      vec_t v;
      v.mode = md; v.fthr = ft; v.ethr = et; v.elat = lat;
      v.m[0] = m0; v.m[1] = m1; v.m[2] = m2; v.m[3] = m3;
      v.ew[0] = w0; v.ew[1] = w1; v.ew[2] = w2; v.ew[3] = w3;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // inj > 0: pulse a fixed-mode start (thr 99) at that cycle; inj < 0: pulse start in the DONE cycle.
   task automatic run_frame(input vec_t v, input int inj, input string tag);
      int         lat;
      int         nwr;
      bit         busy_ok;
      bit         tmo;
      logic [7:0] got [4];
      for (int i = 0; i < 4; i++) begin
         mem[i] = v.m[i];
         got[i] = 8'h5A;
      end
      @(negedge clk);
      start = 1'b1; mode = v.mode; fix_thr = v.fthr;
      @(negedge clk);
      start = 1'b0; mode = 1'b0; fix_thr = '0;
      lat = 1; nwr = 0; busy_ok = 1'b1; tmo = 1'b0;
      if (v.mode) check({tag, "_thr_hold"}, 32'(thr_out), 32'(prev_thr));
      while (!done) begin
         if (wr_en) begin
            nwr++;
            got[wr_addr] = wr_data;
         end
         if (!busy) busy_ok = 1'b0;
         if (lat == inj) begin
            start = 1'b1; mode = 1'b0; fix_thr = 8'd99;
         end else begin
            start = 1'b0;
         end
         if (lat >= 60) begin
            tmo = 1'b1;
            break;
         end
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      check({tag, "_timeout"}, 32'(tmo), 32'd0);
      check({tag, "_latency"}, 32'(lat), 32'(v.elat));
      check({tag, "_busy_run"}, 32'(busy_ok), 32'd1);
      check({tag, "_busy_done"}, 32'(busy), 32'd0);
      check({tag, "_nwrites"}, 32'(nwr), 32'd4);
      for (int i = 0; i < 4; i++)
         check($sformatf("%s_wr%0d", tag, i), 32'(got[i]), 32'(v.ew[i]));
      check({tag, "_thr"}, 32'(thr_out), 32'(v.ethr));
      prev_thr = v.ethr;
      if (inj < 0) begin
         start = 1'b1; mode = 1'b0; fix_thr = 8'd99;
         @(negedge clk);
         start = 1'b0;
         check({tag, "_done_once"}, 32'(done), 32'd0);
         @(negedge clk);
         check({tag, "_start_in_done_ignored"}, 32'({busy, mem_rd}), 32'd0);
         check({tag, "_thr_after"}, 32'(thr_out), 32'(v.ethr));
      end
   endtask

   initial begin
      int nwr;
      int guard;
      vecs[0] = mk(1'b1, 8'd0,   17'd10,    17'd20,    17'd30,    17'd40,    8'd25,  8'd0,   8'd0,   8'd255, 8'd255, 12);
      vecs[1] = mk(1'b0, 8'd20,  17'd10,    17'd20,    17'd30,    17'd40,    8'd20,  8'd0,   8'd255, 8'd255, 8'd255, 6);
      vecs[2] = mk(1'b1, 8'd0,   17'd1000,  17'd1000,  17'd1000,  17'd1000,  8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 12);
      vecs[3] = mk(1'b1, 8'd0,   17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 17'h1FFFF, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 12);
      vecs[4] = mk(1'b0, 8'd255, 17'd254,   17'd255,   17'd256,   17'd0,     8'd255, 8'd0,   8'd255, 8'd255, 8'd0,   6);
      vecs[5] = mk(1'b1, 8'd0,   17'd0,     17'd0,     17'd0,     17'd7,     8'd1,   8'd0,   8'd0,   8'd0,   8'd255, 12);
      vecs[6] = mk(1'b1, 8'd0,   17'd1023,  17'd1,     17'd0,     17'd0,     8'd255, 8'd255, 8'd0,   8'd0,   8'd0,   12);
      vecs[7] = mk(1'b0, 8'd0,   17'd0,     17'd1,     17'd0,     17'd65536, 8'd0,   8'd255, 8'd255, 8'd255, 8'd255, 6);

      repeat (2) @(negedge clk);
      check("reset_outputs", 32'({mem_rd, mem_addr, wr_en, wr_addr, wr_data, thr_out, busy, done}), 32'd0);
      reset = 1'b0;

      for (int i = 0; i < 8; i++) run_frame(vecs[i], 0, $sformatf("vec%0d", i));

      run_frame(vecs[1], 3, "inj_fixed_bin");
      run_frame(vecs[0], 9, "inj_adapt_bin");
      run_frame(vecs[1], -1, "start_in_done");

      // Abort a fixed-mode frame after two writes with an asynchronous reset.
      for (int i = 0; i < 4; i++) mem[i] = vecs[1].m[i];
      @(negedge clk);
      start = 1'b1; mode = 1'b0; fix_thr = 8'd20;
      @(negedge clk);
      start = 1'b0;
      nwr = 0; guard = 0;
      while (nwr < 2 && guard < 20) begin
         if (wr_en) nwr++;
         if (nwr < 2) @(negedge clk);
         guard++;
      end
      check("rst_pre_writes", 32'(nwr), 32'd2);
      #2 reset = 1'b1;
      #1 check("rst_async_outputs",
               32'({mem_rd, mem_addr, wr_en, wr_addr, wr_data, thr_out, busy, done}), 32'd0);
      nwr = 0;
      repeat (4) begin
         @(negedge clk);
         if (wr_en) nwr++;
      end
      check("rst_no_writes", 32'(nwr), 32'd0);
      reset = 1'b0;
      prev_thr = '0;
      repeat (2) @(negedge clk);
      check("rst_idle_after", 32'({busy, mem_rd, wr_en}), 32'd0);

      run_frame(vecs[0], 0, "post_rst_adapt");
      run_frame(vecs[1], 0, "b2b_fixed");
      run_frame(vecs[5], 0, "b2b_adapt");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
